// File: rtl/fighter_pkg.sv
// Shared types and default timing for the fighter character blocks.
// Holds the action state encoding, the default frame counts and the duration counter type.
package fighter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    WINDUP  = 3'd2,
    ACTIVE  = 3'd3,
    RECOVER = 3'd4,
    DEFEND  = 3'd5,
    HITSTUN = 3'd6
  } action_state_t;

  localparam int WINDUP_F_DEF   = 3;
  localparam int ACTIVE_F_DEF   = 2;
  localparam int RECOVER_F_DEF  = 4;
  localparam int HITSTUN_F_DEF  = 6;
  localparam int COOLDOWN_F_DEF = 8;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  // The entry tick already counts as one tick of residency, so the counter
  // holds the ticks that remain after the entry tick.
  function automatic cnt_t residency(input int frames);
    return cnt_t'(frames - 1);
  endfunction

endpackage

// File: rtl/character_action_ctrl_if.sv
// Key/hit inputs and character status outputs of one fighter controller.
// master = game side (key decoder, collision), slave = the controller.
interface character_action_ctrl_if import fighter_pkg::*; ;

  logic          frame_tick;
  logic          enable;
  logic          move_l;
  logic          move_r;
  logic          attack;
  logic          defense;
  logic          hit;

  logic [9:0]    x_pos;
  action_state_t state;
  logic          facing;
  logic          attack_active;
  logic          blocked;
  logic [3:0]    anim_frame;

  modport master (
    output frame_tick, enable, move_l, move_r, attack, defense, hit,
    input  x_pos, state, facing, attack_active, blocked, anim_frame
  );

  modport slave (
    input  frame_tick, enable, move_l, move_r, attack, defense, hit,
    output x_pos, state, facing, attack_active, blocked, anim_frame
  );

endinterface

// File: rtl/frame_counter.sv
// Loadable down-counter advanced by a tick enable; done while the count is zero.
// Used both for action-state duration and for attack cooldown.
module frame_counter
  import fighter_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  cnt_t load_val,
  input  logic tick_en,
  output logic done
);

  cnt_t count_q;

  // NOTE: non-blocking (<=) for all clocked state so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick_en && count_q != '0) begin
      count_q <= count_q - cnt_t'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/character_action_ctrl.sv
// Per-frame action state machine of one fighter: walk, attack sequence, defend, hitstun.
// Everything advances only on enabled frame ticks; blocked is a single-Clk pulse.
module character_action_ctrl
  import fighter_pkg::*;
#(
  parameter logic [9:0] X_INIT     = 10'd100,
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd560,
  parameter logic [9:0] STEP       = 10'd2,
  parameter int         WINDUP_F   = WINDUP_F_DEF,
  parameter int         ACTIVE_F   = ACTIVE_F_DEF,
  parameter int         RECOVER_F  = RECOVER_F_DEF,
  parameter int         HITSTUN_F  = HITSTUN_F_DEF,
  parameter int         COOLDOWN_F = COOLDOWN_F_DEF,
  parameter logic       FACE_INIT  = 1'b0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  character_action_ctrl_if.slave  bus
);

  action_state_t state_q, state_n;
  logic [9:0]    x_q, x_n;
  logic          facing_q, facing_n;
  logic [3:0]    anim_q, anim_n;
  logic          attack_active_q;
  logic          blocked_q, blocked_n;
  logic          prev_attack_q;

  logic tick_en;
  logic attack_rise;
  logic restart;
  logic dur_load, dur_done;
  cnt_t dur_val;
  logic cd_load, cd_done;

  assign tick_en     = bus.frame_tick & bus.enable;
  assign attack_rise = bus.attack & ~prev_attack_q;

  frame_counter u_duration (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tick_en & dur_load),
    .load_val (dur_val),
    .tick_en  (tick_en),
    .done     (dur_done)
  );

  frame_counter u_cooldown (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (tick_en & cd_load),
    .load_val (cnt_t'(COOLDOWN_F)),
    .tick_en  (tick_en),
    .done     (cd_done)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    facing_n  = facing_q;
    blocked_n = 1'b0;
    restart   = 1'b0;
    dur_load  = 1'b0;
    dur_val   = '0;
    cd_load   = 1'b0;

    if (bus.hit && state_q == DEFEND) begin
      blocked_n = 1'b1;
    end else if (bus.hit) begin
      state_n  = HITSTUN;
      restart  = 1'b1;
      dur_load = 1'b1;
      dur_val  = residency(HITSTUN_F);
    end else begin
      unique case (state_q)
        WINDUP: if (dur_done) begin
          state_n  = ACTIVE;
          dur_load = 1'b1;
          dur_val  = residency(ACTIVE_F);
        end
        ACTIVE: if (dur_done) begin
          state_n  = RECOVER;
          dur_load = 1'b1;
          dur_val  = residency(RECOVER_F);
        end
        RECOVER: if (dur_done) begin
          state_n = IDLE;
          cd_load = 1'b1;
        end
        HITSTUN: if (dur_done) begin
          state_n = IDLE;
        end
        IDLE, WALK, DEFEND: begin
          if (bus.defense) begin
            state_n = DEFEND;
          end else if (attack_rise && cd_done) begin
            state_n  = WINDUP;
            dur_load = 1'b1;
            dur_val  = residency(WINDUP_F);
          end else if (bus.move_l ^ bus.move_r) begin
            state_n = WALK;
            if (bus.move_l) begin
              facing_n = 1'b1;
              // 11-bit compare keeps the subtraction from wrapping below X_MIN.
              x_n = ({1'b0, x_q} < ({1'b0, X_MIN} + {1'b0, STEP})) ? X_MIN : x_q - STEP;
            end else begin
              facing_n = 1'b0;
              x_n = (({1'b0, x_q} + {1'b0, STEP}) > {1'b0, X_MAX}) ? X_MAX : x_q + STEP;
            end
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (state_n != state_q || restart) begin
      anim_n = '0;
    end else begin
      anim_n = (anim_q == 4'hF) ? anim_q : anim_q + 4'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= IDLE;
      x_q             <= X_INIT;
      facing_q        <= FACE_INIT;
      anim_q          <= '0;
      attack_active_q <= 1'b0;
      blocked_q       <= 1'b0;
      prev_attack_q   <= 1'b0;
    end else begin
      // blocked must fall on the very next Clk, tick or not.
      blocked_q <= tick_en & blocked_n;
      if (tick_en) begin
        state_q         <= state_n;
        x_q             <= x_n;
        facing_q        <= facing_n;
        anim_q          <= anim_n;
        attack_active_q <= (state_n == ACTIVE);
        prev_attack_q   <= bus.attack;
      end
    end
  end

  assign bus.x_pos         = x_q;
  assign bus.state         = state_q;
  assign bus.facing        = facing_q;
  assign bus.anim_frame    = anim_q;
  assign bus.attack_active = attack_active_q;
  assign bus.blocked       = blocked_q;

endmodule

// File: tb/tb_character_action_ctrl.sv
// Self-checking bench for character_action_ctrl: directed scenarios plus random keys,
// every frame tick compared against a tick-level behavioural model.
module tb_character_action_ctrl;
  import fighter_pkg::*;

  localparam logic [9:0] X_INIT = 10'd100;
  localparam logic [9:0] X_MIN  = 10'd0;
  localparam logic [9:0] X_MAX  = 10'd560;
  localparam logic [9:0] STEP   = 10'd2;
  localparam int WF = 3, AF = 2, RF = 4, HF = 6, CF = 8;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  character_action_ctrl_if bus ();

  character_action_ctrl #(
    .X_INIT(X_INIT), .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP(STEP),
    .WINDUP_F(WF), .ACTIVE_F(AF), .RECOVER_F(RF), .HITSTUN_F(HF), .COOLDOWN_F(CF),
    .FACE_INIT(1'b0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: state as a plain number, age = ticks since entering it, cooldown as
  // the absolute enabled-tick number after which attacks are accepted again.
  int m_st, m_age, m_x, m_face, m_prev, m_cd_until, m_ticks;
  bit m_blocked;

  function automatic int frames_of(input int s);
    case (s)
      2: return WF;
      3: return AF;
      4: return RF;
      6: return HF;
      default: return 0;
    endcase
  endfunction

  function automatic int after_timed(input int s);
    case (s)
      2: return 3;
      3: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_st = 0; m_age = 0; m_x = int'(X_INIT); m_face = 0; m_prev = 0;
    m_cd_until = m_ticks; m_blocked = 0;
  endtask

  task automatic model_tick();
    int  nxt;
    bit  rise, restart;
    nxt     = m_st;
    restart = 0;
    rise    = bus.attack && !m_prev;
    m_prev  = int'(bus.attack);
    m_ticks++;
    m_blocked = 0;
    if (bus.hit && m_st == 5) begin
      m_blocked = 1;
    end else if (bus.hit) begin
      nxt = 6; restart = 1;
    end else if (m_st == 2 || m_st == 3 || m_st == 4 || m_st == 6) begin
      if (m_age >= frames_of(m_st) - 1) begin
        nxt = after_timed(m_st);
        if (m_st == 4) m_cd_until = m_ticks + CF;
      end
    end else if (bus.defense) begin
      nxt = 5;
    end else if (rise && m_ticks > m_cd_until) begin
      nxt = 2;
    end else if (bus.move_l != bus.move_r) begin
      nxt = 1;
      if (bus.move_l) begin
        m_face = 1;
        m_x = (m_x - int'(STEP) < int'(X_MIN)) ? int'(X_MIN) : m_x - int'(STEP);
      end else begin
        m_face = 0;
        m_x = (m_x + int'(STEP) > int'(X_MAX)) ? int'(X_MAX) : m_x + int'(STEP);
      end
    end else begin
      nxt = 0;
    end
    m_age = (nxt != m_st || restart) ? 0 : m_age + 1;
    m_st  = nxt;
  endtask

  task automatic check_all(input string ph);
    check({ph, ".state"},  32'(bus.state),        m_st);
    check({ph, ".x_pos"},  32'(bus.x_pos),        m_x);
    check({ph, ".facing"}, 32'(bus.facing),       m_face);
    check({ph, ".active"}, 32'(bus.attack_active), (m_st == 3) ? 1 : 0);
    check({ph, ".blocked"}, 32'(bus.blocked),     32'(m_blocked));
    check({ph, ".anim"},   32'(bus.anim_frame),   (m_age > 15) ? 15 : m_age);
  endtask

  // One frame tick, then one plain Clk to confirm outputs hold and blocked drops.
  task automatic tick();
    @(negedge Clk) bus.frame_tick = 1'b1;
    @(posedge Clk);
    if (bus.enable) model_tick();
    else m_blocked = 0;
    #1 check_all("tick");
    @(negedge Clk) bus.frame_tick = 1'b0;
    @(posedge Clk);
    #1 m_blocked = 0;
    check_all("hold");
  endtask

  task automatic set_keys(input bit l, input bit r, input bit a, input bit d, input bit h);
    bus.move_l = l; bus.move_r = r; bus.attack = a; bus.defense = d; bus.hit = h;
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1 model_reset();
    check_all("reset");
    @(negedge Clk) Reset = 1'b0;
  endtask

  int exp_seq[$];

  initial begin
    bus.frame_tick = 1'b0;
    bus.enable     = 1'b1;
    set_keys(0, 0, 0, 0, 0);
    m_ticks = 0;
    reset_dut();

    // Attack tap: WINDUP, ACTIVE, RECOVER residencies, then IDLE.
    for (int i = 0; i < WF; i++) exp_seq.push_back(2);
    for (int i = 0; i < AF; i++) exp_seq.push_back(3);
    for (int i = 0; i < RF; i++) exp_seq.push_back(4);
    exp_seq.push_back(0);
    bus.attack = 1'b1;
    foreach (exp_seq[i]) begin
      tick();
      bus.attack = 1'b0;
      check("tap_seq", 32'(bus.state), exp_seq[i]);
    end

    // Held attack gives one sequence only; cooldown gates re-press.
    repeat (10) tick();
    bus.attack = 1'b1;
    repeat (WF + AF + RF + 1) tick();
    check("held_idle", 32'(bus.state), 0);
    repeat (2) tick();
    check("held_no_rewindup", 32'(bus.state), 0);
    bus.attack = 1'b0; tick();
    bus.attack = 1'b1; tick();
    check("cooldown_ignore", 32'(bus.state), 0);
    bus.attack = 1'b0;
    repeat (CF - 4) tick();
    bus.attack = 1'b1; tick();
    check("cooldown_expired", 32'(bus.state), 2);
    bus.attack = 1'b0;
    repeat (12) tick();

    // Walk left into the clamp, both keys to IDLE, walk right into the clamp.
    reset_dut();
    bus.move_l = 1'b1;
    repeat (60) tick();
    check("clamp_left_x", 32'(bus.x_pos), 0);
    check("clamp_left_face", 32'(bus.facing), 1);
    bus.move_r = 1'b1; tick();
    check("both_keys_idle", 32'(bus.state), 0);
    check("both_keys_x", 32'(bus.x_pos), 0);
    bus.move_l = 1'b0;
    repeat (290) tick();
    check("clamp_right_x", 32'(bus.x_pos), 560);
    bus.move_r = 1'b0;

    // Hit during WINDUP, re-hit on the fourth HITSTUN tick.
    reset_dut();
    bus.attack = 1'b1; tick();
    bus.attack = 1'b0; tick();
    bus.hit = 1'b1; tick();
    check("hit_windup", 32'(bus.state), 6);
    bus.hit = 1'b0;
    repeat (3) tick();
    bus.hit = 1'b1; tick();
    check("rehit_anim", 32'(bus.anim_frame), 0);
    bus.hit = 1'b0;
    repeat (HF - 1) tick();
    check("rehit_still_stun", 32'(bus.state), 6);
    tick();
    check("rehit_idle", 32'(bus.state), 0);

    // Defend and block.
    bus.defense = 1'b1; tick();
    bus.hit = 1'b1; tick();
    check("block_state", 32'(bus.state), 5);
    check("block_x", 32'(bus.x_pos), 100);
    tick();
    set_keys(0, 0, 0, 0, 0); tick();

    // Pause: ticks with enable low change nothing.
    bus.enable = 1'b0;
    set_keys(1, 0, 1, 0, 0);
    repeat (5) tick();
    set_keys(0, 0, 0, 0, 0);
    bus.enable = 1'b1;
    tick();

    // Async reset mid-ACTIVE, then the held attack restarts from IDLE.
    reset_dut();
    bus.attack = 1'b1; tick();
    repeat (WF) tick();
    check("pre_reset_active", 32'(bus.state), 3);
    #2 Reset = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    #2 Reset = 1'b0;
    tick();
    check("post_reset_windup", 32'(bus.state), 2);
    bus.attack = 1'b0;

    // Random keys.
    repeat (500) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      set_keys($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 7) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/character_action_ctrl.md
CHARACTER_ACTION_CTRL -- requirements
Module: character_action_ctrl

Interface
REQ-001 SHALL have parameter X_INIT, 10'd100, x position after reset.
REQ-002 SHALL have parameter X_MIN, 10'd0, left position clamp.
REQ-003 SHALL have parameter X_MAX, 10'd560, right position clamp.
REQ-004 SHALL have parameter STEP, 10'd2, pixels moved per walk tick.
REQ-005 SHALL have parameters WINDUP_F=3, ACTIVE_F=2, RECOVER_F=4, HITSTUN_F=6, COOLDOWN_F=8; each is a frame-tick count and each is at least 1.
REQ-006 SHALL have parameter FACE_INIT, 1'b0, facing after reset (0 right, 1 left).
REQ-007 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-008 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port frame_tick  input  1  one-Clk pulse per video frame.
REQ-010 SHALL have port enable  input  1  0 pauses the block (game over/pause).
REQ-011 SHALL have ports move_l, move_r, attack, defense  input  1 each  level key requests from the key decoder.
REQ-012 SHALL have port hit  input  1  opponent hitbox overlaps this character; level.
REQ-013 SHALL have ports x_pos  output  10  character x position; state  output  3  action state; facing  output  1  facing direction.
REQ-014 SHALL have ports attack_active  output  1  hitbox valid; blocked  output  1  one-Clk pulse on a blocked hit; anim_frame  output  4  ticks spent in the current state.

Function
REQ-015 SHALL update internal state and outputs only on Clk edges where frame_tick=1 and enable=1, and SHALL hold all values otherwise; blocked is the only exception.
REQ-016 SHALL drive all outputs from registers, so a response appears at the same edge that samples the tick.
REQ-017 SHALL encode state as IDLE=0, WALK=1, WINDUP=2, ACTIVE=3, RECOVER=4, DEFEND=5, HITSTUN=6; code 7 is unreachable and SHALL recover to IDLE.
REQ-018 SHALL apply this highest priority on each tick: if hit=1 and state=DEFEND, it SHALL stay in DEFEND and pulse blocked for exactly one Clk.
REQ-019 SHALL, on a tick with hit=1 in any other state (including HITSTUN), enter or remain in HITSTUN, reload the duration to HITSTUN_F and force attack_active to 0.
REQ-020 SHALL ignore all key inputs in WINDUP, ACTIVE, RECOVER and HITSTUN.
REQ-021 SHALL keep each of these states for exactly its *_F ticks, then advance WINDUP->ACTIVE->RECOVER->IDLE and HITSTUN->IDLE.
REQ-022 SHALL, in IDLE, WALK or DEFEND, choose the next state in this order: defense=1 -> DEFEND; attack rising edge with cooldown=0 -> WINDUP; exactly one of move_l/move_r -> WALK; otherwise IDLE.
REQ-023 SHALL return to IDLE when both move_l and move_r are asserted.
REQ-024 SHALL detect the attack rising edge as attack=1 at this tick and attack=0 at the previous tick, and SHALL update the previous-sample register on every enabled tick.
REQ-025 SHALL, on each WALK tick, set facing to the walk direction and move x_pos by STEP in that direction, clamped to [X_MIN, X_MAX] with no wrap-around.
REQ-026 SHALL load the cooldown counter with COOLDOWN_F on the RECOVER->IDLE transition and decrement it on each enabled tick while it is nonzero, including in the loading state's following ticks.
REQ-027 SHALL set attack_active=1 if and only if state=ACTIVE.
REQ-028 SHALL reset anim_frame to 0 on every state change and increment it per tick within a state, saturating at 15; a HITSTUN reload also resets it to 0.

Reset
REQ-029 SHALL, while Reset=1 and regardless of Clk, force state=IDLE, x_pos=X_INIT, facing=FACE_INIT, attack_active=0, blocked=0, anim_frame=0, cooldown=0, duration counter=0 and previous attack sample=0.
REQ-030 SHALL, when reset is asserted mid-attack or mid-HITSTUN, abort the action, and the first enabled tick after release SHALL be evaluated from IDLE.

Structure
REQ-031 SHALL define the action_state_t enum and the default frame-count constants in the shared package fighter_pkg.
REQ-032 SHALL implement durations with one sub-module, frame_counter, a down-counter with load, tick-enable and done outputs, instantiated once for state duration and once for cooldown.

Verification
REQ-033 SHALL verify: tap attack from IDLE -> WINDUP for 3 ticks, ACTIVE for 2 ticks with attack_active=1, RECOVER for 4 ticks, then IDLE.
REQ-034 SHALL verify: attack held across the whole sequence -> no second WINDUP; after release, re-press within 8 ticks of IDLE -> ignored; re-press after 8 ticks -> WINDUP.
REQ-035 SHALL verify: move_l held 60 ticks from x=100 -> x_pos steps 98, 96 ... and clamps at 0, facing=1; move_l and move_r together -> IDLE with x unchanged.
REQ-036 SHALL verify: hit during WINDUP -> HITSTUN for 6 ticks with attack_active=0; hit again at tick 4 -> 6 more ticks.
REQ-037 SHALL verify: defense held and hit asserted -> state stays 5, blocked is high for exactly 1 Clk, x_pos unchanged.
REQ-038 SHALL verify: enable=0 with ticks -> all outputs frozen; Reset pulsed mid-ACTIVE without a Clk edge -> outputs immediately at reset values.
